// File: rtl/muldiv_pkg.sv
// Shared constants and types for the RV32M sequencer.
// Imported by the interface, the divide step and the controller.
package muldiv_pkg;

    localparam int XLEN = 32;
    localparam int DIV_ITERS = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] neg_if(
        input logic            neg,
        input logic [XLEN-1:0] v
    );
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request, result and multiplier signals of the M-extension sequencer.
// slave is the sequencer side, master the pipeline/multiplier side.
interface muldiv_ctrl_if;
    import muldiv_pkg::*;

    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            mul_start_o;
    logic [1:0]      mul_op_o;
    logic [XLEN-1:0] mul_a_o;
    logic [XLEN-1:0] mul_b_o;
    logic [XLEN-1:0] mul_result_i;
    logic            res_valid_o;
    logic [XLEN-1:0] res_o;
    logic            res_ready_i;
    logic            stall_o;

    modport slave (
        input  req_valid_i, op_i, rs1_i, rs2_i, flush_i,
        input  mul_result_i, res_ready_i,
        output req_ready_o, mul_start_o, mul_op_o, mul_a_o, mul_b_o,
        output res_valid_o, res_o, stall_o
    );

    modport master (
        output req_valid_i, op_i, rs1_i, rs2_i, flush_i,
        output mul_result_i, res_ready_i,
        input  req_ready_o, mul_start_o, mul_op_o, mul_a_o, mul_b_o,
        input  res_valid_o, res_o, stall_o
    );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division iteration, MSB first.
// The quotient register doubles as the dividend shift source.
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN:0]   rem_nx,
    output logic [XLEN-1:0] quot_nx
);

    logic [XLEN+1:0] sh;
    logic [XLEN+1:0] trial;
    logic            neg;

    always_comb begin
        sh      = {rem, quot[XLEN-1]};
        trial   = sh - {2'b00, dvs};
        neg     = trial[XLEN+1];
        rem_nx  = neg ? sh[XLEN:0] : trial[XLEN:0];
        quot_nx = {quot[XLEN-2:0], ~neg};
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage RV32M sequencer: drives an external multiplier and
// runs division internally, holding the result until consumed.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input logic clk,
    input logic rst,
    muldiv_ctrl_if.slave bus
);

    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT);
    localparam logic [4:0] DIV_LAST = 5'(DIV_ITERS - 1);

    state_t          state;
    state_t          state_nx;
    logic [4:0]      cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] res_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quot_q;

    logic            accept;
    logic            div_zero;
    logic            div_ovf;
    logic            in_signed;
    logic            op_signed;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   rem_nx;
    logic [XLEN-1:0] quot_nx;
    logic [XLEN-1:0] quot_fix;
    logic [XLEN-1:0] rem_fix;

    assign in_signed = !bus.op_i[0];
    assign accept    = state == S_IDLE && bus.req_valid_i && !bus.flush_i;
    assign div_zero  = bus.rs2_i == '0;
    assign div_ovf   = in_signed && bus.rs1_i == INT_MIN && bus.rs2_i == '1;

    assign op_signed = !op_q[0];
    assign dvs       = neg_if(op_signed && b_q[XLEN-1], b_q);
    assign quot_fix  = neg_if(op_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]), quot_nx);
    assign rem_fix   = neg_if(op_signed && a_q[XLEN-1], rem_nx[XLEN-1:0]);

    div_step u_div_step (
        .rem     (rem_q),
        .quot    (quot_q),
        .dvs     (dvs),
        .rem_nx  (rem_nx),
        .quot_nx (quot_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (bus.flush_i) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        if (!bus.op_i[2])            state_nx = S_MUL;
                        else if (div_zero || div_ovf) state_nx = S_DONE;
                        else                          state_nx = S_DIV;
                    end
                end
                S_MUL:  if (cnt == MUL_LAST) state_nx = S_DONE;
                S_DIV:  if (cnt == DIV_LAST) state_nx = S_DONE;
                S_DONE: if (bus.res_ready_i) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_ready_o = state == S_IDLE;
        bus.stall_o     = state != S_IDLE;
        bus.mul_start_o = state == S_MUL && cnt == '0;
        bus.res_valid_o = state == S_DONE;
        bus.mul_op_o    = op_q;
        bus.mul_a_o     = a_q;
        bus.mul_b_o     = b_q;
        bus.res_o       = res_q;
    end

    // Datapath; a flush freezes everything so a late multiplier
    // result or a half-finished quotient never reaches res_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= bus.op_i[1:0];
            a_q    <= bus.rs1_i;
            b_q    <= bus.rs2_i;
            rem_q  <= '0;
            quot_q <= neg_if(in_signed && bus.rs1_i[XLEN-1], bus.rs1_i);
            if (bus.op_i[2] && div_zero) begin
                res_q <= bus.op_i[1] ? bus.rs1_i : DIV0_QUOT;
            end else if (bus.op_i[2] && div_ovf) begin
                res_q <= bus.op_i[1] ? '0 : INT_MIN;
            end
        end else if (!bus.flush_i) begin
            unique case (state)
                S_MUL: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == MUL_LAST) res_q <= bus.mul_result_i;
                end
                S_DIV: begin
                    cnt    <= cnt + 5'd1;
                    rem_q  <= rem_nx;
                    quot_q <= quot_nx;
                    if (cnt == DIV_LAST) res_q <= op_q[1] ? rem_fix : quot_fix;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for RV32M operations in the EX stage.
- Accepts one MUL/DIV-class request at a time and drives an external fixed-latency multiplier through a start/operand interface.
- Runs RV32M division internally as a 32-iteration restoring divider.
- Holds the result under a valid/ready handshake until the pipeline takes it, and raises stall_o while busy so the hazard logic can freeze IF/ID/EX.

Parameters:
- MUL_LAT, 2: cycles from the mul_start_o cycle to the cycle mul_result_i is valid. Legal range 1..15.
- XLEN, 32: operand width. Only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid_i  in  1  M-extension request present.
- req_ready_o  out  1  block can accept a request (high only in IDLE).
- op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  in  32  dividend / multiplicand.
- rs2_i  in  32  divisor / multiplier.
- flush_i  in  1  cancel the in-flight operation.
- mul_start_o  out  1  one-cycle start pulse to the multiplier.
- mul_op_o  out  2  op_i[1:0] of the accepted request, registered.
- mul_a_o  out  32  registered rs1, stable from accept until IDLE.
- mul_b_o  out  32  registered rs2, stable from accept until IDLE.
- mul_result_i  in  32  multiplier result.
- res_valid_o  out  1  result available.
- res_o  out  32  result.
- res_ready_i  in  1  pipeline consumes the result.
- stall_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: state IDLE, counter 0. res_valid_o, res_o, mul_start_o, mul_op_o, mul_a_o, mul_b_o, stall_o all 0. req_ready_o 1.
- States: IDLE, MUL, DIV, DONE.
- Accept: on the edge T where state is IDLE, req_valid_i=1 and flush_i=0:
  - latch op, rs1, rs2;
  - op<4 -> MUL, counter=0;
  - op>=4 with divisor 0 or signed overflow -> DONE directly;
  - otherwise -> DIV, counter=0.
- MUL:
  - mul_start_o=1 in the first MUL cycle only.
  - Counter increments each cycle.
  - In the cycle where counter==MUL_LAT, capture mul_result_i into res_o and go to DONE.
  - res_valid_o rises at edge T+MUL_LAT+2.
- DIV, sign handling:
  - Signed ops use |rs1| and |rs2|; unsigned ops use raw values.
  - One restoring step per cycle, MSB first; 32 cycles, 5-bit counter 0..31.
  - On the step with counter==31, apply signs: quotient negated when operand signs differ; remainder takes the sign of rs1.
- DIV, result: select quotient (DIV/DIVU) or remainder (REM/REMU) into res_o, then go to DONE. res_valid_o rises at edge T+33.
- Special cases (res_valid_o at edge T+1):
  - divisor 0: quotient 0xFFFFFFFF, remainder = rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DONE:
  - res_valid_o=1, and res_o is held stable until res_ready_i=1.
  - On the handshake edge: IDLE, res_valid_o=0.
  - req_ready_o stays 0 in DONE, so back-to-back ops have a minimum one-cycle IDLE gap.
- Flush:
  - flush_i=1 in any state -> IDLE at the next edge. res_valid_o=0; res_o is unchanged.
  - A multiplier result still in flight is never sampled.
  - flush_i with req_valid_i in IDLE: flush wins, the request is not accepted.
  - flush_i with res_ready_i in DONE: IDLE, same as a normal handshake.
- rst mid-operation: same as flush, and additionally all outputs return to their reset values.
- stall_o is combinational from state: high in MUL, DIV and DONE.
- Widths: the remainder accumulator is 33 bits (sign of the trial subtraction). All arithmetic is modulo 2^32.

Decomposition:
- Package muldiv_pkg:
  - XLEN;
  - funct3 op localparams (OP_MUL..OP_REMU);
  - state encoding (IDLE/MUL/DIV/DONE);
  - DIV_ITERS=32;
  - constants DIV0_QUOT=32'hFFFFFFFF and INT_MIN=32'h80000000.
- Sub-module div_step: combinational single restoring-divide iteration.
  - Inputs: 33-bit partial remainder, quotient-shift register, divisor.
  - Outputs: next remainder and next quotient.
  - Instantiated once inside muldiv_ctrl.

Test Plan:
1. DIVU rs1=100, rs2=7 -> stall_o high T+1..T+33, res_valid_o at T+33, res_o=14; REMU same operands -> 2.
2. DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
3. DIV rs1=5, rs2=0 -> 0xFFFFFFFF at T+1; REMU rs1=5, rs2=0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; both at T+1.
4. MUL 3*4, stub multiplier with MUL_LAT=2 -> mul_start_o single pulse at T+1, mul_op_o=0, res_o=12 valid at T+4. Hold res_ready_i=0 five cycles -> res_o stable, req_ready_o=0, stall_o=1.
5. Flush on the 10th DIV cycle -> IDLE next edge, no res_valid_o. Then DIVU 9/3 accepted -> 3 at T'+33.
6. flush_i and req_valid_i together in IDLE -> not accepted, req_ready_o stays 1. rst asserted mid-MUL -> all outputs at reset values next edge.
